// File: rtl/uart_mmio_periph.sv
// uart_mmio_periph
//   Memory-mapped 8N1 UART. A byte store to 0x400 (uart_write_en) queues
//   uart_wdata into the TX FIFO. A byte load from 0x404 (uart_read_en)
//   returns the RX FIFO head on uart_rdata in the same cycle and pops it at
//   the clock edge.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   uart_write_en     store strobe, uart_wdata[7:0] byte to send
//   uart_read_en      load strobe, uart_rdata[31:0] {24'b0, head} or FFFFFFFF
//   rx / tx           serial in (asynchronous) / serial out (idle high)
//   tx_busy           TX FSM active or TX FIFO holding data
//   rx_valid          RX FIFO non-empty
//   err_flags         sticky {rx_frame_err, rx_overrun, tx_overflow}
//
// Build option
//   UART_LOOPBACK_EN  feed the RX synchronizer from the internal tx line
//                     instead of the rx pin (on-board self-test)
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, pop the FIFO head when one is present
//   TX_START | start bit (0) for one bit time
//   TX_DATA  | 8 data bits, LSB first
//   TX_STOP  | stop bit (1); chains straight into the next START if queued
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | wait for a falling edge on rx_s
//   RX_START | half bit time, then confirm the start bit (reject glitches)
//   RX_DATA  | sample 8 bits, one bit time apart, LSB first
//   RX_STOP  | sample the stop bit; push the byte or flag a framing error
//   RX_WAIT  | after a framing error, wait for the line to return high

module uart_mmio_periph #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_write_en,
  input  logic [7:0]  uart_wdata,
  input  logic        uart_read_en,
  output logic [31:0] uart_rdata,
  input  logic        rx,
  output logic        tx,
  output logic        tx_busy,
  output logic        rx_valid,
  output logic [2:0]  err_flags
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   WRAP_ONLY = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr_ptr, tx_rd_ptr;
  logic        tx_empty, tx_full, tx_pop, tx_push;
  logic [7:0]  tx_head;

  // ---------------- RX FIFO ----------------
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wr_ptr, rx_rd_ptr;
  logic        rx_empty, rx_full, rx_pop, rx_push, rx_push_req;

  // ---------------- TX FSM ----------------
  tx_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;

  // ---------------- RX path ----------------
  rx_state_t   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;
  logic        rx_src, rx_meta, rx_s;
  logic        rx_frame_err, rx_overrun, tx_overflow;

  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = ((tx_wr_ptr ^ tx_rd_ptr) == WRAP_ONLY);
  assign tx_head  = tx_mem[tx_rd_ptr[AW-1:0]];
  // The FSM takes the next byte from IDLE, or directly at the end of a stop
  // bit so back-to-back bytes have no idle gap.
  assign tx_pop   = !tx_empty &&
                    ((tx_state == TX_IDLE) ||
                     ((tx_state == TX_STOP) && (tx_cnt == '0)));
  assign tx_push  = uart_write_en && (!tx_full || tx_pop);

  assign rx_empty    = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full     = ((rx_wr_ptr ^ rx_rd_ptr) == WRAP_ONLY);
  assign rx_pop      = uart_read_en && !rx_empty;
  assign rx_push_req = (rx_state == RX_STOP) && (rx_cnt == '0) && rx_s;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  assign rx_valid   = !rx_empty;
  assign uart_rdata = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rd_ptr[AW-1:0]]};
  assign err_flags  = {rx_frame_err, rx_overrun, tx_overflow};

`ifdef UART_LOOPBACK_EN
  assign rx_src = tx;
`else
  assign rx_src = rx;
`endif

  // FIFO storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= uart_wdata;
    if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      tx_overflow <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (uart_write_en && !tx_push) tx_overflow <= 1'b1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push_req && !rx_push) rx_overrun <= 1'b1;
    end
  end

  // tx and tx_busy are registered from the current state, so the line lags
  // the FSM by one cycle; every bit still lasts CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_busy <= (tx_state != TX_IDLE) || !tx_empty;
      case (tx_state)
        TX_START: tx <= 1'b0;
        TX_DATA:  tx <= tx_shift[tx_idx];
        default:  tx <= 1'b1;
      endcase

      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_shift <= tx_head;
            tx_cnt   <= BIT_LAST;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_cnt   <= BIT_LAST;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_idx == 3'd7) tx_state <= TX_STOP;
            else                tx_idx   <= tx_idx + 1'b1;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) begin
            if (tx_pop) begin
              tx_shift <= tx_head;
              tx_cnt   <= BIT_LAST;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_meta <= rx_src;
      rx_s    <= rx_meta;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_cnt   <= HALF_LAST;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_s) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_cnt   <= BIT_LAST;
              rx_idx   <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift[rx_idx] <= rx_s;
            rx_cnt <= BIT_LAST;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else                rx_idx   <= rx_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            if (rx_s) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_WAIT;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_WAIT: begin
          if (rx_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_mmio_periph.md
Name: uart_mmio_periph

Overview:
- Memory-mapped 8N1 UART peripheral that consumes the controller's UART strobes.
- A byte store (SB) to 0x400 asserts uart_write_en and pushes rs2[7:0] into a TX FIFO.
- A byte load (LB) from 0x404 asserts uart_read_en, returns the RX FIFO head combinationally in the same cycle, and pops it at the clock edge.
- Sits beside data memory; its uart_rdata is muxed into the load-result path.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per UART bit (100 MHz / 9600 baud); legal range >= 4.
- FIFO_DEPTH, 16, entries in each of the TX and RX FIFOs; power of two, >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- uart_write_en  input  1  store strobe from controller (SB to 0x400)
- uart_wdata  input  8  byte to transmit (rs2[7:0])
- uart_read_en  input  1  load strobe from controller (LB from 0x404)
- uart_rdata  output  32  {24'b0, RX head} when RX not empty, else 32'hFFFFFFFF
- rx  input  1  serial input from pin, asynchronous
- tx  output  1  serial output, idle high
- tx_busy  output  1  TX FSM not IDLE or TX FIFO non-empty
- rx_valid  output  1  RX FIFO non-empty
- err_flags  output  3  sticky {rx_frame_err, rx_overrun, tx_overflow}

Behaviour:
- One clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - tx=1, tx_busy=0, rx_valid=0, err_flags=0, uart_rdata=32'hFFFFFFFF.
  - Both FIFOs emptied; both FSMs to IDLE; baud counters cleared.
- Reset mid-frame aborts the frame immediately. tx is driven high on the next edge; no partial byte is retained.
- Both FIFOs are circular, with pointers of log2(FIFO_DEPTH) bits plus one wrap bit.
  - full: pointers differ only in the wrap bit.
  - empty: pointers are equal.
- TX FIFO:
  - uart_write_en pushes at the edge.
  - Push while full: byte dropped, tx_overflow set.
  - Push while full with a same-cycle TX pop: accepted.
- TX FSM states and transitions:
  - IDLE: if FIFO non-empty, pop into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles; bit index 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Back-to-back bytes: a new START begins the cycle after STOP ends; no extra idle bit.
  - First start bit: appears 2 cycles after the write edge (1 cycle FIFO, 1 cycle IDLE pop).
- RX front end: 2-flop synchronizer on rx; sync output is rx_s.
- RX FSM states and transitions:
  - IDLE: on rx_s==0, go to START.
  - START: wait CLKS_PER_BIT/2 cycles, resample. If rx_s==1 it is a glitch: return to IDLE, no flag. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, push the byte. If 0, drop it, set rx_frame_err, and wait for rx_s==1 before IDLE.
- RX FIFO push:
  - Push while full: byte dropped, rx_overrun set.
  - Push while full with a same-cycle uart_read_en pop: accepted.
- Read path:
  - uart_rdata is combinational from the head entry and empty flag.
  - uart_read_en pops at the edge only if non-empty.
  - Read while empty returns 32'hFFFFFFFF; no state change.
  - Push into an empty FIFO with a same-cycle read: the read returns FFFFFFFF and the byte is retained.
- err_flags are sticky until reset.
- uart_write_en and uart_read_en asserted together: both are honoured independently.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- Defined: the RX synchronizer input is the internal tx signal, the rx port is ignored, and the tx pin still drives normally. Used for on-board self-test.
- Undefined: RX is sourced from the rx port only.

Test Plan:
- Reset: assert reset for 2 cycles during an active TX frame -> tx=1 next cycle, tx_busy=0, uart_rdata=FFFFFFFF, err_flags=0.
- TX byte (CLKS_PER_BIT=4): write 0xA5 -> tx shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, 4 cycles each; tx_busy deasserts after 40 cycles.
- RX byte: drive 0x3C serially on rx -> rx_valid=1, uart_rdata=0x0000003C; uart_read_en pops it; next read returns FFFFFFFF.
- RX overrun (FIFO_DEPTH=4): send 5 bytes 0x01..0x05 without reads -> rx_overrun=1; reads return 0x01..0x04, then FFFFFFFF.
- Framing/glitch:
  - 1-cycle low pulse on rx: nothing pushed, no flag.
  - Frame 0x55 with stop=0: nothing pushed, rx_frame_err=1.
- Loopback (UART_LOOPBACK_EN): write 0x7E, 0x81 back-to-back -> RX FIFO receives 0x7E then 0x81; TX full-FIFO write sets tx_overflow.
